// File: rtl/board_line_judge.sv
// board_line_judge: sequential NxN K-in-a-row judge, one candidate line per clock.
module board_line_judge #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int IW = (N > 2) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2*N*N-1:0]  board,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              draw,
    output logic [IW-1:0]     win_row,
    output logic [IW-1:0]     win_col,
    output logic [1:0]        win_dir
);
    localparam int NC  = 4 * N * N;
    localparam int IXW = $clog2(NC);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           st_q;
    logic [IXW-1:0]   i_q;
    logic [2*N*N-1:0] snap_q;
    logic             found_q;
    logic [1:0]       code;
    logic [1:0]       hit;
    logic             ok;
    logic             full;
    int               r, c, dr, dc, idx;

    // Signed int arithmetic keeps the anti-diagonal bound check from wrapping.
    always_comb begin
        r    = (int'(i_q) >> 2) / N;
        c    = (int'(i_q) >> 2) % N;
        dr   = (i_q[1:0] == 2'd0) ? 0 : 1;
        dc   = (i_q[1:0] == 2'd1) ? 0 : (i_q[1:0] == 2'd3) ? -1 : 1;
        ok   = (r + dr * (K - 1) < N) && (c + dc * (K - 1) >= 0) && (c + dc * (K - 1) < N);
        code = snap_q[2*(r*N+c) +: 2];
        ok   = ok && (code == 2'b01 || code == 2'b10);
        idx  = 0;
        for (int k = 1; k < K; k++) begin
            idx = ok ? (r + dr * k) * N + c + dc * k : 0;
            ok  = ok && (snap_q[2*idx +: 2] == code);
        end
        hit = ok ? code : 2'b00;
    end

    always_comb begin
        full = 1'b1;
        for (int j = 0; j < N * N; j++)
            full = full && (snap_q[2*j +: 2] == 2'b01 || snap_q[2*j +: 2] == 2'b10);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= IDLE;
            i_q     <= '0;
            snap_q  <= '0;
            found_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            winner  <= 2'b00;
            draw    <= 1'b0;
            win_row <= '0;
            win_col <= '0;
            win_dir <= 2'd0;
        end else begin
            case (st_q)
                IDLE: if (start) begin
                    st_q    <= SCAN;
                    snap_q  <= board;
                    i_q     <= '0;
                    found_q <= 1'b0;
                    busy    <= 1'b1;
                    winner  <= 2'b00;
                    draw    <= 1'b0;
                    win_row <= '0;
                    win_col <= '0;
                    win_dir <= 2'd0;
                end
                SCAN: begin
                    winner <= winner | hit;
                    if (hit != 2'b00 && !found_q) begin
                        found_q <= 1'b1;
                        win_row <= IW'(r);
                        win_col <= IW'(c);
                        win_dir <= i_q[1:0];
                    end
                    if (i_q == IXW'(NC - 1)) begin
                        st_q <= DONE;
                        done <= 1'b1;
                        draw <= ((winner | hit) == 2'b00) && full;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                default: begin
                    st_q <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                    i_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_line_judge.sv
// tb_board_line_judge: random and directed checks of N=3,K=3 and N=5,K=4 judges against a line-walking model.
module tb_board_line_judge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       st = '0;
    logic [1:0][49:0] brd = '0;
    logic [1:0]       bsy, dn, drw;
    logic [1:0][1:0]  wnr, wdir;
    logic [1:0][2:0]  wrow, wcol;
    int checks = 0;
    int passed = 0;

    typedef struct packed {int w; int d; int r; int c; int x;} res_t;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int cellv(logic [49:0] b, int n, int r, int c);
        if (r < 0 || r >= n || c < 0 || c >= n) return -1;
        return int'(b[2*(r*n+c) +: 2]);
    endfunction

    // Walk every line start and direction in scan order; first win sets the location.
    function automatic res_t judge(logic [49:0] b, int n, int k);
        res_t o;
        bit first, full;
        o = '0;
        first = 1;
        full = 1;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (cellv(b, n, r, c) == 0 || cellv(b, n, r, c) == 3) full = 0;
                for (int d = 0; d < 4; d++) begin
                    int dy, dx, p, v;
                    bit win;
                    dy = (d == 0) ? 0 : 1;
                    dx = (d == 1) ? 0 : (d == 3) ? -1 : 1;
                    p = cellv(b, n, r, c);
                    win = (p == 1 || p == 2);
                    for (int t = 1; t < k; t++) begin
                        v = cellv(b, n, r + dy * t, c + dx * t);
                        if (v != p) win = 0;
                    end
                    if (win) begin
                        o.w = o.w | p;
                        if (first) begin
                            o.r = r; o.c = c; o.x = d; first = 0;
                        end
                    end
                end
            end
        o.d = (o.w == 0 && full) ? 1 : 0;
        return o;
    endfunction

    function automatic logic [49:0] put(logic [49:0] b, int n, int r, int c, logic [1:0] v);
        b[2*(r*n+c) +: 2] = v;
        return b;
    endfunction

    function automatic logic [49:0] rb(int n, bit dense);
        logic [49:0] b;
        int v;
        b = '0;
        for (int j = 0; j < n * n; j++) begin
            v = $urandom_range(0, 9);
            b[2*j +: 2] = dense ? 2'($urandom_range(1, 2)) :
                          (v < 4) ? 2'b01 : (v < 8) ? 2'b10 : (v < 9) ? 2'b00 : 2'b11;
        end
        return b;
    endfunction

    genvar g;
    for (g = 0; g < 2; g++) begin : u
        localparam int NN  = g ? 5 : 3;
        localparam int KK  = g ? 4 : 3;
        localparam int IWG = $clog2(NN);
        localparam int L   = 4 * NN * NN;
        logic [IWG-1:0] r_o, c_o;
        board_line_judge #(.N(NN), .K(KK)) dut (
            .clk(clk), .reset(reset), .start(st[g]), .board(brd[g][2*NN*NN-1:0]),
            .busy(bsy[g]), .done(dn[g]), .winner(wnr[g]), .draw(drw[g]),
            .win_row(r_o), .win_col(c_o), .win_dir(wdir[g])
        );
        assign wrow[g] = 3'(r_o);
        assign wcol[g] = 3'(c_o);

        int   cnt = 0;
        bit   rv = 0;
        bit   z = 1;
        res_t ex = '0;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= 0; rv <= 0; z <= 1;
            end else if (cnt == 0) begin
                if (st[g]) begin
                    cnt <= 1; rv <= 0; z <= 0; ex <= judge(brd[g], NN, KK);
                end
            end else begin
                cnt <= (cnt == L + 1) ? 0 : cnt + 1;
                if (cnt == L) rv <= 1;
            end
        end

        always @(negedge clk) begin
            chk("busy", int'(bsy[g]), int'(cnt != 0));
            chk("done", int'(dn[g]), int'(cnt == L + 1));
            if (cnt == 0 || cnt == L + 1) begin
                if (rv) begin
                    chk("winner", int'(wnr[g]), ex.w);
                    chk("draw", int'(drw[g]), ex.d);
                    chk("win_row", int'(wrow[g]), ex.r);
                    chk("win_col", int'(wcol[g]), ex.c);
                    chk("win_dir", int'(wdir[g]), ex.x);
                end else if (z) begin
                    chk("zero_out", int'({wnr[g], drw[g], wrow[g], wcol[g], wdir[g]}), 0);
                end
            end
        end
    end

    task automatic start_run(int gi, logic [49:0] b);
        @(negedge clk);
        #1 brd[gi] = b; st[gi] = 1'b1;
        @(negedge clk);
        #1 st[gi] = 1'b0;
    endtask

    task automatic wait_done(int gi, output int n);
        n = 1;
        while (!dn[gi] && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!dn[gi]) chk("done_timeout", 0, 1);
    endtask

    task automatic res(string nm, int gi, int w, int d, int r, int c, int x);
        chk({nm, "_winner"}, int'(wnr[gi]), w);
        chk({nm, "_draw"}, int'(drw[gi]), d);
        chk({nm, "_row"}, int'(wrow[gi]), r);
        chk({nm, "_col"}, int'(wcol[gi]), c);
        chk({nm, "_dir"}, int'(wdir[gi]), x);
    endtask

    initial begin
        logic [49:0] b;
        int n, cnt_done;
        int t3[9] = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
        res_t m;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        res("reset", 0, 0, 0, 0, 0, 0);
        chk("reset_busy", int'(bsy[0]), 0);

        b = 50'h15;
        start_run(0, b);
        wait_done(0, n);
        chk("lat_n3", n, 37);
        res("top_row", 0, 1, 0, 0, 0, 0);

        b = '0;
        b = put(b, 3, 0, 0, 2'b01); b = put(b, 3, 0, 1, 2'b01); b = put(b, 3, 0, 2, 2'b10);
        b = put(b, 3, 1, 0, 2'b01); b = put(b, 3, 1, 1, 2'b10); b = put(b, 3, 2, 0, 2'b10);
        b = put(b, 3, 2, 1, 2'b01);
        start_run(0, b);
        wait_done(0, n);
        res("anti", 0, 2, 0, 0, 2, 3);

        b = '0;
        for (int j = 0; j < 9; j++) b[2*j +: 2] = 2'(t3[j]);
        m = judge(b, 3, 3);
        chk("model_draw", m.d, 1);
        start_run(0, b);
        wait_done(0, n);
        res("draw", 0, 0, 1, 0, 0, 0);
        b = put(b, 3, 2, 2, 2'b00);
        m = judge(b, 3, 3);
        chk("model_nodraw", m.d, 0);
        start_run(0, b);
        wait_done(0, n);
        res("nodraw", 0, 0, 0, 0, 0, 0);

        b = '0;
        for (int r = 0; r < 3; r++) begin
            b = put(b, 3, r, 0, 2'b01);
            b = put(b, 3, r, 2, 2'b10);
        end
        m = judge(b, 3, 3);
        chk("model_conflict", m.w, 3);
        start_run(0, b);
        wait_done(0, n);
        res("conflict", 0, 3, 0, 0, 0, 1);

        start_run(0, 50'h15);
        repeat (4) @(negedge clk);
        #1 brd[0] = b;
        repeat (5) @(negedge clk);
        #1 st[0] = 1'b1;
        @(negedge clk);
        #1 st[0] = 1'b0;
        wait_done(0, n);
        res("snapshot", 0, 1, 0, 0, 0, 0);

        start_run(0, 50'h15);
        repeat (19) @(negedge clk);
        #1 reset = 1'b1;
        #1 res("abort", 0, 0, 0, 0, 0, 0);
        chk("abort_busy", int'(bsy[0]), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        cnt_done = 0;
        repeat (45) begin
            @(negedge clk);
            if (dn[0]) cnt_done++;
        end
        chk("abort_no_done", cnt_done, 0);

        b = '0;
        for (int t = 1; t < 5; t++) b = put(b, 5, t, t, 2'b01);
        for (int t = 1; t < 4; t++) b = put(b, 5, 0, t, 2'b01);
        start_run(1, b);
        wait_done(1, n);
        chk("lat_n5", n, 101);
        res("diag5", 1, 1, 0, 1, 1, 2);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            #1;
            reset = (cyc == 700 || cyc == 701);
            for (int gi = 0; gi < 2; gi++) begin
                st[gi] = ($urandom_range(0, 3) == 0);
                brd[gi] = rb(gi ? 5 : 3, $urandom_range(0, 2) == 0);
            end
        end
        #1 st = '0;
        repeat (110) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
